// File: rtl/uart_pkg.sv
// Types, frame constants and helpers shared by the UART transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE0 = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_EVEN  = 2'b10,
    PAR_NONE3 = 2'b11
  } parity_e;

  typedef enum logic [1:0] {
    B2400  = 2'b00,
    B4800  = 2'b01,
    B9600  = 2'b10,
    B19200 = 2'b11
  } baud_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int FRAME_BITS = 11;

  typedef struct packed {
    logic [7:0] data;
    parity_e    par;
    baud_e      baud;
  } tx_req_t;

  function automatic int unsigned baud_div(input int unsigned clk_freq, input baud_e b);
    case (b)
      B2400:   return clk_freq / 2400;
      B4800:   return clk_freq / 4800;
      B9600:   return clk_freq / 9600;
      default: return clk_freq / 19200;
    endcase
  endfunction

  // "None" still occupies the parity slot, driven as a mark.
  function automatic logic parity_bit(input logic [7:0] d, input parity_e p);
    case (p)
      PAR_ODD:  return ~^d;
      PAR_EVEN: return ^d;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_unit_if.sv
// Byte handshake and serial-line status bundle between a byte source and uart_tx_unit.
interface uart_tx_unit_if;
  import uart_pkg::*;

  logic       tx_valid;
  logic [7:0] data_in;
  parity_e    parity_type;
  baud_e      baud_rate;
  logic       tx_ready;
  logic       data_tx;
  logic       active_flag;
  logic       done_flag;

  modport master (
    output tx_valid, data_in, parity_type, baud_rate,
    input  tx_ready, data_tx, active_flag, done_flag
  );

  modport slave (
    input  tx_valid, data_in, parity_type, baud_rate,
    output tx_ready, data_tx, active_flag, done_flag
  );
endinterface

// File: rtl/uart_tx_baud_tick.sv
// Bit-period counter: counts 0..DIV-1 while running, bit_end marks the last clock of a bit.
module uart_tx_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] div_in,
  output logic             bit_end
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;

  // bit_end must not depend on clear: a reload at the end of STOP is itself triggered by bit_end.
  always_comb begin
    div_d   = clear ? div_in : div_q;
    bit_end = run && (cnt_q == div_q - DIV_W'(1));
    if (clear || !run || bit_end) cnt_d = '0;
    else                          cnt_d = cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmitter: 11-bit frame (start, D0..D7, parity, stop), LSB first.
// UART_TX_HOLD_EN adds a one-entry holding register so frames can run back-to-back.
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input logic           clock,
  input logic           reset,
  uart_tx_unit_if.slave tx_if
);

  localparam int DIV_W = $clog2(baud_div(CLK_FREQ, B2400) + 1);

  if (baud_div(CLK_FREQ, B19200) < 2) begin : g_div_chk
    $fatal(1, "uart_tx_unit: CLK_FREQ too low, bit divisor below 2");
  end

  function automatic logic [DIV_W-1:0] div_of(input baud_e b);
    return DIV_W'(baud_div(CLK_FREQ, b));
  endfunction

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [2:0] idx_q, idx_d;
  logic       data_tx_q, data_tx_d;
  logic       tx_ready, accept, load, bit_end;
  tx_req_t    in_req, req;

`ifdef UART_TX_HOLD_EN
  tx_req_t hold_q, hold_d;
  logic    hold_full_q, hold_full_d;
  assign tx_ready = !hold_full_q;
`else
  assign tx_ready = (state_q == IDLE);
`endif

  uart_tx_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clock   (clock),
    .reset   (reset),
    .clear   (load),
    .run     (state_q != IDLE),
    .div_in  (div_of(req.baud)),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    idx_d   = idx_q;
    load    = 1'b0;
    in_req  = '{data: tx_if.data_in, par: tx_if.parity_type, baud: tx_if.baud_rate};
    req     = in_req;
    accept  = tx_if.tx_valid && tx_ready;
`ifdef UART_TX_HOLD_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef UART_TX_HOLD_EN
        if (hold_full_q) begin
          load        = 1'b1;
          req         = hold_q;
          hold_full_d = 1'b0;
        end else if (accept) begin
          load = 1'b1;
        end
`else
        if (accept) load = 1'b1;
`endif
      end
      START: if (bit_end) begin
        state_d = DATA;
        idx_d   = 3'd0;
      end
      DATA: if (bit_end) begin
        shift_d = {1'b1, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        state_d = IDLE;
`ifdef UART_TX_HOLD_EN
        if (hold_full_q) begin
          load        = 1'b1;
          req         = hold_q;
          hold_full_d = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_TX_HOLD_EN
    // Bytes accepted while shifting park in the holding register; a same-cycle drain keeps the new byte.
    if (accept && state_q != IDLE) begin
      hold_d      = in_req;
      hold_full_d = 1'b1;
    end
`endif
    if (load) begin
      state_d = START;
      shift_d = req.data;
      par_d   = parity_bit(req.data, req.par);
      idx_d   = 3'd0;
    end
    case (state_d)
      START:   data_tx_d = 1'b0;
      DATA:    data_tx_d = shift_d[0];
      PARITY:  data_tx_d = par_d;
      default: data_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      par_q       <= 1'b1;
      idx_q       <= '0;
      data_tx_q   <= 1'b1;
`ifdef UART_TX_HOLD_EN
      hold_q      <= '0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      idx_q       <= idx_d;
      data_tx_q   <= data_tx_d;
`ifdef UART_TX_HOLD_EN
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end

  assign tx_if.tx_ready    = tx_ready;
  assign tx_if.data_tx     = data_tx_q;
  assign tx_if.active_flag = (state_q != IDLE);
  assign tx_if.done_flag   = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit at CLK_FREQ=76_800 (bit divisors 32/16/8/4).
module tb_uart_tx_unit;
  import uart_pkg::*;

  logic clock, reset;
  int   tests_run = 0;
  int   fails = 0;

  uart_tx_unit_if tx_if ();

  uart_tx_unit #(.CLK_FREQ(76_800)) dut (
    .clock (clock),
    .reset (reset),
    .tx_if (tx_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog");
  end

  // Call between edges; returns just after the edge that samples the offer.
  task automatic offer(input logic [7:0] d, input parity_e p, input baud_e b, output logic acc);
    tx_if.data_in     = d;
    tx_if.parity_type = p;
    tx_if.baud_rate   = b;
    tx_if.tx_valid    = 1'b1;
    acc = tx_if.tx_ready;
    @(posedge clock);
    #1 tx_if.tx_valid = 1'b0;
  endtask

  // Observes one frame after an accept (cycle 1 = first cycle after the accept edge).
  task automatic capture(input int div, input bit mutate, output logic [10:0] bits, output int bad,
                         output int dcnt, output int dat, output int acnt, output logic rdy_after);
    logic s0;
    bits = '1; bad = 0; dcnt = 0; dat = -1; acnt = 0; rdy_after = 1'b0; s0 = 1'b1;
    for (int c = 1; c <= 11*div + 2; c++) begin
      @(negedge clock);
      if (mutate && c == 3*div) begin
        tx_if.data_in = 8'hFF; tx_if.baud_rate = B19200; tx_if.parity_type = PAR_EVEN;
      end
      if (c <= 11*div) begin
        if ((c-1) % div == 0) begin s0 = tx_if.data_tx; bits[(c-1)/div] = s0; end
        else if (tx_if.data_tx !== s0) bad++;
      end
      if (tx_if.done_flag === 1'b1) begin dcnt++; dat = c; end
      if (tx_if.active_flag === 1'b1) acnt++;
      if (c == 11*div + 1) rdy_after = tx_if.tx_ready;
    end
  endtask

  task automatic test_reset();
    int bad;
    tx_if.tx_valid = 1'b0; tx_if.data_in = 8'h00;
    tx_if.parity_type = PAR_NONE0; tx_if.baud_rate = B2400;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    tests_run++;
    if ({tx_if.data_tx, tx_if.tx_ready, tx_if.active_flag, tx_if.done_flag} !== 4'b1100) begin
      fails++; $display("FAIL reset_outputs: got tx/rdy/act/done=%b want 1100",
        {tx_if.data_tx, tx_if.tx_ready, tx_if.active_flag, tx_if.done_flag});
    end
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if ({tx_if.data_tx, tx_if.tx_ready, tx_if.active_flag, tx_if.done_flag} !== 4'b1100) bad++;
    end
    tests_run++;
    if (bad != 0) begin fails++; $display("FAIL reset_idle_100: %0d busy cycles, want 0", bad); end
  endtask

  task automatic test_even_fast();
    logic acc, rdy; logic [10:0] bits; int bad, dcnt, dat, acnt;
    offer(8'hA5, PAR_EVEN, B19200, acc);
    capture(4, 1'b0, bits, bad, dcnt, dat, acnt, rdy);
    tests_run++; if (acc !== 1'b1) begin fails++; $display("FAIL a5_even_accept: got %b want 1", acc); end
    tests_run++; if (bits !== {1'b1, 1'b0, 8'hA5, 1'b0}) begin
      fails++; $display("FAIL a5_even_bits: got %b want %b", bits, {1'b1, 1'b0, 8'hA5, 1'b0}); end
    tests_run++; if (bad != 0) begin fails++; $display("FAIL a5_even_bit_hold: %0d glitches want 0", bad); end
    tests_run++; if (dcnt != 1 || dat != 44) begin
      fails++; $display("FAIL a5_even_done: got %0d pulses at %0d want 1 at 44", dcnt, dat); end
    tests_run++; if (acnt != 44) begin fails++; $display("FAIL a5_even_active: got %0d want 44", acnt); end
    tests_run++; if (rdy !== 1'b1) begin fails++; $display("FAIL a5_even_ready_back: got %b want 1", rdy); end
  endtask

  task automatic test_odd_slow_mutate();
    logic acc, rdy; logic [10:0] bits; int bad, dcnt, dat, acnt;
    offer(8'hA5, PAR_ODD, B2400, acc);
    capture(32, 1'b1, bits, bad, dcnt, dat, acnt, rdy);
    tests_run++; if (bits !== {1'b1, 1'b1, 8'hA5, 1'b0} || bad != 0) begin
      fails++; $display("FAIL a5_odd_bits: got %b (%0d glitches) want %b", bits, bad, {1'b1, 1'b1, 8'hA5, 1'b0}); end
    tests_run++; if (dcnt != 1 || dat != 352 || acnt != 352) begin
      fails++; $display("FAIL a5_odd_length: done %0d at %0d active %0d want 1 at 352 active 352", dcnt, dat, acnt); end
  endtask

  task automatic test_parity_none();
    logic acc, rdy; logic [10:0] bits; int bad, dcnt, dat, acnt;
    parity_e pn [2] = '{PAR_NONE0, PAR_NONE3};
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      offer(8'h00, pn[i], B9600, acc);
      capture(8, 1'b0, bits, bad, dcnt, dat, acnt, rdy);
      tests_run++; if (bits[9] !== 1'b1 || bits[10] !== 1'b1 || bits[0] !== 1'b0 || bad != 0) begin
        fails++; $display("FAIL none%0d_framing: got %b want %b", i, bits, {1'b1, 1'b1, 8'h00, 1'b0}); end
      tests_run++; if (bits[8:1] !== 8'h00) begin
        fails++; $display("FAIL none%0d_loop_data: got %h want 00", i, bits[8:1]); end
    end
  endtask

  task automatic test_reset_midframe();
    logic acc, rdy; logic [10:0] bits; int bad, dcnt, dat, acnt;
    @(negedge clock);
    offer(8'hF7, PAR_EVEN, B9600, acc);
    repeat (36) @(negedge clock);
    tests_run++; if (tx_if.data_tx !== 1'b0) begin
      fails++; $display("FAIL midframe_d3_low: got %b want 0", tx_if.data_tx); end
    reset = 1'b1;
    @(negedge clock);
    tests_run++; if ({tx_if.data_tx, tx_if.tx_ready, tx_if.active_flag} !== 3'b110) begin
      fails++; $display("FAIL midframe_reset: got tx/rdy/act=%b want 110",
        {tx_if.data_tx, tx_if.tx_ready, tx_if.active_flag}); end
    reset = 1'b0;
    @(negedge clock);
    offer(8'h3C, PAR_EVEN, B9600, acc);
    capture(8, 1'b0, bits, bad, dcnt, dat, acnt, rdy);
    tests_run++; if (bits !== {1'b1, 1'b0, 8'h3C, 1'b0} || bad != 0 || dat != 88) begin
      fails++; $display("FAIL after_reset_3c: got %b done@%0d want %b done@88", bits, dat, {1'b1, 1'b0, 8'h3C, 1'b0}); end
  endtask

`ifdef UART_TX_HOLD_EN
  task automatic test_back_to_back();
    logic acc1, acc2; logic line [0:200]; logic rdy [0:200]; int dcnt, d1, d2;
    logic [10:0] f1, f2;
    @(negedge clock);
    offer(8'h11, PAR_EVEN, B9600, acc1);
    offer(8'h22, PAR_EVEN, B9600, acc2);
    dcnt = 0; d1 = -1; d2 = -1;
    for (int c = 2; c <= 180; c++) begin
      @(negedge clock);
      line[c] = tx_if.data_tx; rdy[c] = tx_if.tx_ready;
      if (tx_if.done_flag === 1'b1) begin dcnt++; if (dcnt == 1) d1 = c; else d2 = c; end
    end
    for (int k = 0; k < 11; k++) begin f1[k] = line[2 + k*8]; f2[k] = line[90 + k*8]; end
    tests_run++; if (acc1 !== 1'b1 || acc2 !== 1'b1) begin
      fails++; $display("FAIL hold_accepts: got %b%b want 11", acc1, acc2); end
    tests_run++; if (rdy[2] !== 1'b0 || rdy[89] !== 1'b1) begin
      fails++; $display("FAIL hold_ready: got c2=%b c89=%b want 0 1", rdy[2], rdy[89]); end
    tests_run++; if (line[88] !== 1'b1 || line[89] !== 1'b0) begin
      fails++; $display("FAIL hold_no_gap: got c88=%b c89=%b want 1 0", line[88], line[89]); end
    tests_run++; if (f1 !== {1'b1, 1'b0, 8'h11, 1'b0} || f2 !== {1'b1, 1'b0, 8'h22, 1'b0}) begin
      fails++; $display("FAIL hold_frames: got %b %b want %b %b", f1, f2,
        {1'b1, 1'b0, 8'h11, 1'b0}, {1'b1, 1'b0, 8'h22, 1'b0}); end
    tests_run++; if (dcnt != 2 || d1 != 88 || d2 != 176) begin
      fails++; $display("FAIL hold_done: got %0d pulses at %0d,%0d want 2 at 88,176", dcnt, d1, d2); end
  endtask
`else
  task automatic test_back_to_back();
    logic acc; logic line [0:120]; logic rdy [0:120]; int dcnt, d2, start2;
    logic [10:0] f1, f2;
    @(negedge clock);
    offer(8'hA5, PAR_EVEN, B19200, acc);
    tx_if.data_in = 8'h5A; tx_if.parity_type = PAR_ODD; tx_if.tx_valid = 1'b1;
    dcnt = 0; d2 = -1; start2 = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      line[c] = tx_if.data_tx; rdy[c] = tx_if.tx_ready;
      if (tx_if.done_flag === 1'b1) begin dcnt++; d2 = c; end
      if (c > 44 && start2 < 0 && tx_if.data_tx === 1'b0) begin start2 = c; tx_if.tx_valid = 1'b0; end
    end
    tx_if.tx_valid = 1'b0;
    for (int k = 0; k < 11; k++) begin f1[k] = line[1 + k*4]; f2[k] = line[46 + k*4]; end
    tests_run++; if (f1 !== {1'b1, 1'b0, 8'hA5, 1'b0}) begin
      fails++; $display("FAIL b2b_first_unaffected: got %b want %b", f1, {1'b1, 1'b0, 8'hA5, 1'b0}); end
    tests_run++; if (rdy[44] !== 1'b0 || rdy[45] !== 1'b1 || line[45] !== 1'b1) begin
      fails++; $display("FAIL b2b_gap: got rdy44=%b rdy45=%b line45=%b want 0 1 1", rdy[44], rdy[45], line[45]); end
    tests_run++; if (start2 != 46) begin fails++; $display("FAIL b2b_second_start: got %0d want 46", start2); end
    tests_run++; if (f2 !== {1'b1, 1'b1, 8'h5A, 1'b0}) begin
      fails++; $display("FAIL b2b_second_bits: got %b want %b", f2, {1'b1, 1'b1, 8'h5A, 1'b0}); end
    tests_run++; if (dcnt != 2 || d2 != 89) begin
      fails++; $display("FAIL b2b_done: got %0d pulses last at %0d want 2 last at 89", dcnt, d2); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    test_reset();
    test_even_fast();
    test_odd_slow_mutate();
    test_parity_none();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
